// File: rtl/sync_count_n_if.sv
// sync_count_n_if -- control/status bundle for the sync_count_n counter.
//
// Signals:
//   en  count enable (1 = step one count this cycle)
//   up  direction (1 = increment, 0 = decrement)
//   ld  synchronous parallel load strobe
//   d   parallel load value, N bits
//   q   registered count value, N bits
//   tc  combinational terminal-count flag
//   co  registered carry/borrow pulse
//
// Modports: master drives the controls and observes the count;
// slave is the counter itself.
interface sync_count_n_if #(
    parameter int N = 4
);
    logic         en;
    logic         up;
    logic         ld;
    logic [N-1:0] d;
    logic [N-1:0] q;
    logic         tc;
    logic         co;

    modport master (
        output en, up, ld, d,
        input  q, tc, co
    );

    modport slave (
        input  en, up, ld, d,
        output q, tc, co
    );
endinterface

// File: rtl/sync_count_n.sv
// sync_count_n -- N-bit up/down counter with a programmable terminal count,
// wrap or saturate overflow mode, parallel load, and a carry/borrow pulse.
//
// Parameters:
//   N    counter width, 2..32
//   MAX  terminal (highest) count, 1..2**N-1
//   SAT  0 = wrap at the bounds, 1 = saturate at the bounds
//
// Ports:
//   CLK  sole clock, rising edge
//   RST  synchronous active-high reset; clears q and co
//   bus  sync_count_n_if slave modport (en, up, ld, d in; q, tc, co out)
//
// Priority on every edge: RST, then ld, then en, then hold.
// tc flags that the next enabled step hits a bound. co is high for the one
// cycle after a step that hit a bound (tc with no ld and no RST).
module sync_count_n #(
    parameter int          N   = 4,
    parameter int unsigned MAX = (32'd1 << N) - 32'd1,
    parameter int          SAT = 0
) (
    input logic           CLK,
    input logic           RST,
    sync_count_n_if.slave bus
);
    localparam logic [N-1:0] MAX_V = N'(MAX);
    // MAX at the all-ones value lets the adder's own rollover provide the wrap.
    localparam bit FULL = (MAX_V == {N{1'b1}});

    logic [N-1:0] q_reg;
    logic         co_reg;

    logic         at_max;
    logic         at_zero;
    logic         tc_w;
    logic [N-1:0] inc_v;
    logic [N-1:0] dec_v;
    logic [N-1:0] ld_v;

    assign at_max  = (q_reg == MAX_V);
    assign at_zero = (q_reg == '0);
    assign tc_w    = bus.en & ((bus.up & at_max) | (~bus.up & at_zero));

    // Wrapping next values and the load clamp.
    generate
        if (FULL) begin : g_full
            assign inc_v = q_reg + N'(1);
            assign dec_v = q_reg - N'(1);
            assign ld_v  = bus.d;
        end else begin : g_part
            assign inc_v = at_max  ? '0    : q_reg + N'(1);
            assign dec_v = at_zero ? MAX_V : q_reg - N'(1);
            assign ld_v  = (bus.d > MAX_V) ? MAX_V : bus.d;
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            q_reg  <= '0;
            co_reg <= 1'b0;
        end else begin
            // A load cancels the bound event even when tc is high.
            co_reg <= tc_w & ~bus.ld;
            if (bus.ld) begin
                q_reg <= ld_v;
            end else if (bus.en) begin
                if (bus.up) begin
                    q_reg <= ((SAT != 0) && at_max) ? q_reg : inc_v;
                end else begin
                    q_reg <= ((SAT != 0) && at_zero) ? q_reg : dec_v;
                end
            end
        end
    end

    assign bus.q  = q_reg;
    assign bus.tc = tc_w;
    assign bus.co = co_reg;
endmodule

// File: tb/tb_sync_count_n.sv
// tb_sync_count_n -- directed bench for sync_count_n.
// Three counters share one stimulus stream:
//   dut_a  N=4, MAX=9,  SAT=0
//   dut_b  N=4, MAX=9,  SAT=1
//   dut_c  N=4, MAX=15 (default), SAT=0
// Each scenario checks only the instance it targets.
module tb_sync_count_n;
    logic       CLK = 1'b0;
    logic       RST;
    logic       en;
    logic       up;
    logic       ld;
    logic [3:0] d;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    sync_count_n_if #(.N(4)) if_a ();
    sync_count_n_if #(.N(4)) if_b ();
    sync_count_n_if #(.N(4)) if_c ();

    assign if_a.en = en;
    assign if_a.up = up;
    assign if_a.ld = ld;
    assign if_a.d  = d;
    assign if_b.en = en;
    assign if_b.up = up;
    assign if_b.ld = ld;
    assign if_b.d  = d;
    assign if_c.en = en;
    assign if_c.up = up;
    assign if_c.ld = ld;
    assign if_c.d  = d;

    sync_count_n #(.N(4), .MAX(9), .SAT(0)) dut_a (.CLK(CLK), .RST(RST), .bus(if_a.slave));
    sync_count_n #(.N(4), .MAX(9), .SAT(1)) dut_b (.CLK(CLK), .RST(RST), .bus(if_b.slave));
    sync_count_n #(.N(4), .SAT(0))          dut_c (.CLK(CLK), .RST(RST), .bus(if_c.slave));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Advance one rising edge and sample 1 ns later.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    int exp_q [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};

    initial begin
        // Reset overrides load and enable.
        RST = 1'b1; ld = 1'b1; en = 1'b1; up = 1'b1; d = 4'd5;
        tick();
        check("rst a.q", 32'(if_a.q), 0);
        check("rst a.co", 32'(if_a.co), 0);
        check("rst b.q", 32'(if_b.q), 0);
        check("rst c.q", 32'(if_c.q), 0);

        // Up count with wrap at 9; first edge after reset steps normally.
        RST = 1'b0; ld = 1'b0; en = 1'b1; up = 1'b1;
        for (int k = 0; k < 12; k++) begin
            #1;
            check($sformatf("up%0d a.tc", k), 32'(if_a.tc), (k == 9) ? 1 : 0);
            tick();
            check($sformatf("up%0d a.q", k), 32'(if_a.q), 32'(exp_q[k]));
            check($sformatf("up%0d a.co", k), 32'(if_a.co), (k == 9) ? 1 : 0);
        end

        // Load above MAX clamps; load wins over enable and cancels the bound.
        en = 1'b0; ld = 1'b1; d = 4'd13;
        tick();
        check("ld13 a.q", 32'(if_a.q), 9);
        check("ld13 a.co", 32'(if_a.co), 0);
        en = 1'b1; up = 1'b1; d = 4'd4;
        #1;
        check("ld4 a.tc", 32'(if_a.tc), 1);
        tick();
        check("ld4 a.q", 32'(if_a.q), 4);
        check("ld4 a.co", 32'(if_a.co), 0);

        // Hold with en low regardless of up.
        ld = 1'b0; en = 1'b0; up = 1'b0;
        #1;
        check("hold a.tc", 32'(if_a.tc), 0);
        tick();
        check("hold0 a.q", 32'(if_a.q), 4);
        up = 1'b1;
        tick();
        check("hold1 a.q", 32'(if_a.q), 4);

        // Direction toggle every cycle from 5.
        ld = 1'b1; d = 4'd5;
        tick();
        check("ld5 a.q", 32'(if_a.q), 5);
        ld = 1'b0; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            up = (i % 2 == 0);
            #1;
            check($sformatf("tog%0d a.tc", i), 32'(if_a.tc), 0);
            tick();
            check($sformatf("tog%0d a.q", i), 32'(if_a.q), (i % 2 == 0) ? 6 : 5);
            check($sformatf("tog%0d a.co", i), 32'(if_a.co), 0);
        end

        // Reset on a bound-event cycle suppresses co.
        en = 1'b0; ld = 1'b1; d = 4'd9;
        tick();
        check("ld9 a.q", 32'(if_a.q), 9);
        ld = 1'b0; en = 1'b1; up = 1'b1; RST = 1'b1;
        #1;
        check("rstb a.tc", 32'(if_a.tc), 1);
        tick();
        check("rstb a.q", 32'(if_a.q), 0);
        check("rstb a.co", 32'(if_a.co), 0);
        RST = 1'b0; en = 1'b0;
        tick();
        check("post a.q", 32'(if_a.q), 0);
        check("post a.co", 32'(if_a.co), 0);
        en = 1'b1; up = 1'b1;
        tick();
        check("post1 a.q", 32'(if_a.q), 1);

        // Saturating down count stuck at 0: co on every following cycle.
        RST = 1'b1; en = 1'b0; ld = 1'b0;
        tick();
        RST = 1'b0; en = 1'b1; up = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("sat%0d b.tc", i), 32'(if_b.tc), 1);
            tick();
            check($sformatf("sat%0d b.q", i), 32'(if_b.q), 0);
            check($sformatf("sat%0d b.co", i), 32'(if_b.co), 1);
        end
        en = 1'b0;
        #1;
        check("satoff b.tc", 32'(if_b.tc), 0);
        tick();
        check("satoff b.co", 32'(if_b.co), 0);
        check("satoff b.q", 32'(if_b.q), 0);

        // Saturating up count holds at MAX.
        ld = 1'b1; d = 4'd12;
        tick();
        check("satld b.q", 32'(if_b.q), 9);
        ld = 1'b0; en = 1'b1; up = 1'b1;
        tick();
        check("satup b.q", 32'(if_b.q), 9);
        check("satup b.co", 32'(if_b.co), 1);
        en = 1'b0;
        tick();
        check("satup2 b.co", 32'(if_b.co), 0);

        // Full-range counter: down from 0 wraps to 15, then 14, then holds.
        RST = 1'b1;
        tick();
        RST = 1'b0; en = 1'b1; up = 1'b0;
        #1;
        check("dn0 c.tc", 32'(if_c.tc), 1);
        tick();
        check("dn0 c.q", 32'(if_c.q), 15);
        check("dn0 c.co", 32'(if_c.co), 1);
        #1;
        check("dn1 c.tc", 32'(if_c.tc), 0);
        tick();
        check("dn1 c.q", 32'(if_c.q), 14);
        check("dn1 c.co", 32'(if_c.co), 0);
        en = 1'b0;
        #1;
        check("dnh c.tc", 32'(if_c.tc), 0);
        tick();
        check("dnh c.q", 32'(if_c.q), 14);
        check("dnh c.co", 32'(if_c.co), 0);

        // Full-range counter: up from 15 rolls to 0.
        ld = 1'b1; d = 4'd15;
        tick();
        check("ld15 c.q", 32'(if_c.q), 15);
        ld = 1'b0; en = 1'b1; up = 1'b1;
        #1;
        check("roll c.tc", 32'(if_c.tc), 1);
        tick();
        check("roll c.q", 32'(if_c.q), 0);
        check("roll c.co", 32'(if_c.co), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sync_count_n.md
SYNC_COUNT_N -- requirements
Module: sync_count_n

Interface
REQ-001 Parameter N, default 4, counter width in bits; legal range 2..32.
REQ-002 Parameter MAX, default 2**N-1, terminal (highest) count value; legal range 1..2**N-1.
REQ-003 Parameter SAT, default 0, overflow mode: 0 = wrap, 1 = saturate at bound.
REQ-004 CLK  input  1  sole clock; all state updates on rising edge.
REQ-005 RST  input  1  synchronous, active-high reset.
REQ-006 EN  input  1  count enable; high = step one count this cycle.
REQ-007 UP  input  1  direction; 1 = increment, 0 = decrement.
REQ-008 LD  input  1  synchronous parallel load strobe.
REQ-009 D  input  N  parallel load value.
REQ-010 Q  output  N  registered count value.
REQ-011 TC  output  1  combinational terminal-count flag.
REQ-012 CO  output  1  registered carry/borrow pulse.

Function
REQ-013 Per-edge priority SHALL be RST, then LD, then EN, then hold.
REQ-014 LD=1: Q SHALL take D next edge, or MAX if D>MAX, regardless of EN/UP.
REQ-015 LD=0, EN=1, UP=1, Q<MAX: Q SHALL become Q+1 next edge.
REQ-016 LD=0, EN=1, UP=0, Q>0: Q SHALL become Q-1 next edge.
REQ-017 LD=0, EN=1, UP=1, Q==MAX: Q SHALL become 0 if SAT=0 and hold MAX if SAT=1.
REQ-018 LD=0, EN=1, UP=0, Q==0: Q SHALL become MAX if SAT=0 and hold 0 if SAT=1.
REQ-019 LD=0, EN=0: Q SHALL hold; the value on UP has no effect.
REQ-020 TC SHALL equal EN & ((UP & Q==MAX) | (~UP & Q==0)), with no register stage.
REQ-021 Bound event = TC & ~LD & ~RST in the current cycle.
REQ-022 CO SHALL be high for exactly the one cycle following each bound event, in both SAT modes, and low otherwise.
REQ-023 Consecutive bound events (SAT=1 with EN held at bound, or MAX=1 wrapping) SHALL give CO high on each following cycle, with no merging or suppression.
REQ-024 A direction change mid-count SHALL take effect on the same edge and need no idle cycle.
REQ-025 Q SHALL never leave the range 0..MAX after reset, for any input sequence.
REQ-026 All arithmetic SHALL be N-bit unsigned; a MAX of 2**N-1 SHALL use natural rollover with no extra comparator state.
REQ-027 X/Z on D SHALL not propagate to Q unless LD=1.

Reset
REQ-028 RST=1 at an edge: Q SHALL be 0 and CO SHALL be 0 next cycle, overriding LD and EN.
REQ-029 RST asserted mid-count or on a bound-event cycle: the pending CO pulse SHALL be suppressed.
REQ-030 The first edge with RST=0 SHALL apply normal REQ-013 priority; no recovery cycle.
REQ-031 The block SHALL contain no initial-block or power-up state that sets function; RST is the only defined start point.

Verification (N=4, MAX=9 unless noted)
REQ-032 Reset, then EN=1, UP=1 for 12 edges, SAT=0 -> Q runs 1..9,0,1,2; TC high while Q==9; CO high exactly one cycle after Q 9->0.
REQ-033 SAT=1, UP=0, start Q=0, EN=1 for 3 edges -> Q stays 0; TC high throughout; CO high on each of the 3 following cycles.
REQ-034 LD=1, D=13 -> Q=9 next edge; then LD=1, EN=1, D=4 in the same cycle -> Q=4, no step, CO=0.
REQ-035 Q=5, UP toggled each cycle with EN=1 -> Q alternates 6,5,6,5; TC=0; CO=0.
REQ-036 Q=9, UP=1, EN=1, RST=1 on the same edge -> Q=0, CO=0 the next cycle.
REQ-037 N=4, MAX=15, SAT=0, down-count from 0 -> Q=15, CO pulse, then 14; EN=0 -> hold with TC=0.
